// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 definitions: FSM states, I2C control bytes and controller opcodes.
package ssd1306_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WINDOW,
        ST_PIXELS,
        ST_DONE
    } state_t;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [7:0] OP_DISP_ON     = 8'hAF;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_START_LINE  = 8'h40;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
    localparam logic [7:0] OP_SEG_NORMAL  = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] OP_COM_NORMAL  = 8'hC0;
    localparam logic [7:0] OP_COM_FLIP    = 8'hC8;
    localparam logic [7:0] OP_COM_PINS    = 8'hDA;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;
    localparam logic [7:0] OP_RESUME_RAM  = 8'hA4;
    localparam logic [7:0] OP_NORMAL      = 8'hA6;
    localparam logic [7:0] OP_INVERSE     = 8'hA7;
    localparam logic [7:0] OP_SCROLL_OFF  = 8'h2E;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;

    localparam int INIT_LEN   = 26;
    localparam int WINDOW_LEN = 6;

endpackage

// File: rtl/ssd1306_fb_ram.sv
// Framebuffer: one write port, one registered read-first read port.
module ssd1306_fb_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH))
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ssd1306_frame_streamer.sv
// SSD1306 sequencer: init list once after reset, then address window + full frame per refresh,
// offered byte-by-byte to an I2C byte engine over a valid/ready handshake.
module ssd1306_frame_streamer
    import ssd1306_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h3C,
    parameter int         WIDTH    = 128,
    parameter int         HEIGHT   = 32,
    parameter logic [7:0] CONTRAST = 8'h8F,
    parameter bit         INVERT   = 1'b0,
    parameter bit         FLIP     = 1'b1,
    localparam int        PAGES    = HEIGHT / 8,
    localparam int        FB_DEPTH = WIDTH * PAGES,
    localparam int        AW       = $clog2(FB_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic          fb_we,
    input  logic [AW-1:0] fb_waddr,
    input  logic [7:0]    fb_wdata,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [6:0]    tx_addr,
    output logic          tx_rw,
    output logic [7:0]    tx_ctrl,
    output logic [7:0]    tx_data,
    output logic          tx_last,
    output logic          busy,
    output logic          init_done,
    output logic          frame_done
);

    localparam int IW = AW + 1;

    state_t        state;
    logic [IW-1:0] idx;
    logic          pending;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    init_byte, win_byte, cur_byte;
    logic [IW-1:0] last_idx;

    assign tx_addr = I2C_ADDR;
    assign tx_rw   = 1'b0;

    // Look one byte ahead on acceptance so the RAM output is ready during the single idle cycle.
    assign rd_addr = (state == ST_PIXELS) ? AW'(idx + IW'(tx_valid & tx_ready)) : '0;

    ssd1306_fb_ram #(.DEPTH(FB_DEPTH), .AW(AW)) u_fb (
        .clk   (clk),
        .we    (fb_we),
        .waddr (fb_waddr),
        .wdata (fb_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        init_byte = 8'h00;
        case (int'(idx))
            0:  init_byte = OP_DISP_OFF;
            1:  init_byte = OP_CLK_DIV;
            2:  init_byte = 8'h80;
            3:  init_byte = OP_MUX_RATIO;
            4:  init_byte = 8'(HEIGHT - 1);
            5:  init_byte = OP_DISP_OFFSET;
            6:  init_byte = 8'h00;
            7:  init_byte = OP_START_LINE;
            8:  init_byte = OP_CHARGE_PUMP;
            9:  init_byte = 8'h14;
            10: init_byte = OP_ADDR_MODE;
            11: init_byte = 8'h00;
            12: init_byte = FLIP ? OP_SEG_REMAP : OP_SEG_NORMAL;
            13: init_byte = FLIP ? OP_COM_FLIP : OP_COM_NORMAL;
            14: init_byte = OP_COM_PINS;
            15: init_byte = (HEIGHT == 32) ? 8'h02 : 8'h12;
            16: init_byte = OP_CONTRAST;
            17: init_byte = CONTRAST;
            18: init_byte = OP_PRECHARGE;
            19: init_byte = 8'hF1;
            20: init_byte = OP_VCOMH;
            21: init_byte = 8'h40;
            22: init_byte = OP_RESUME_RAM;
            23: init_byte = INVERT ? OP_INVERSE : OP_NORMAL;
            24: init_byte = OP_SCROLL_OFF;
            25: init_byte = OP_DISP_ON;
            default: init_byte = 8'h00;
        endcase
    end

    always_comb begin
        win_byte = 8'h00;
        case (int'(idx))
            0: win_byte = OP_COL_ADDR;
            1: win_byte = 8'h00;
            2: win_byte = 8'(WIDTH - 1);
            3: win_byte = OP_PAGE_ADDR;
            4: win_byte = 8'h00;
            5: win_byte = 8'(PAGES - 1);
            default: win_byte = 8'h00;
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        last_idx = '0;
        case (state)
            ST_INIT:   begin cur_byte = init_byte; last_idx = IW'(INIT_LEN - 1);   end
            ST_WINDOW: begin cur_byte = win_byte;  last_idx = IW'(WINDOW_LEN - 1); end
            ST_PIXELS: begin cur_byte = rd_data;   last_idx = IW'(FB_DEPTH - 1);   end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            pending    <= 1'b0;
            tx_valid   <= 1'b0;
            tx_ctrl    <= CTRL_CMD;
            tx_data    <= 8'h00;
            tx_last    <= 1'b0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != ST_IDLE && start)
                pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!init_done) begin
                        state   <= ST_INIT;
                        idx     <= '0;
                        tx_ctrl <= CTRL_CMD;
                        busy    <= 1'b1;
                    end else if (start || pending || cont) begin
                        state   <= ST_WINDOW;
                        idx     <= '0;
                        tx_ctrl <= CTRL_CMD;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                ST_INIT, ST_WINDOW, ST_PIXELS: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= cur_byte;
                        tx_last  <= (idx == last_idx);
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        idx      <= idx + 1'b1;
                        if (tx_last) begin
                            idx <= '0;
                            case (state)
                                ST_INIT: begin
                                    state     <= ST_IDLE;
                                    busy      <= 1'b0;
                                    init_done <= 1'b1;
                                end
                                ST_WINDOW: begin
                                    state   <= ST_PIXELS;
                                    tx_ctrl <= CTRL_DATA;
                                end
                                default: begin
                                    state      <= ST_DONE;
                                    frame_done <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Bench: 128x32 flipped panel (dut 0) and 128x64 unflipped inverted panel (dut 1), checked
// against byte streams built from the panel rules and a framebuffer model.
module tb_ssd1306_frame_streamer;

    localparam int W_FD = 0, W_IDLE = 1, W_INIT = 2, W_LOG = 3;
    localparam int LOG_MAX = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [2];
    logic       cont [2];
    logic       fb_we [2];
    logic [9:0] fb_waddr [2];
    logic [7:0] fb_wdata [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [6:0] tx_addr [2];
    logic       tx_rw [2];
    logic [7:0] tx_ctrl [2];
    logic [7:0] tx_data [2];
    logic       tx_last [2];
    logic       busy [2];
    logic       init_done [2];
    logic       frame_done [2];

    bit          bp [2];
    int          n_tests = 0, n_fail = 0;
    logic [16:0] log_ent [2][LOG_MAX];
    int          log_n [2];
    int          fd_cnt [2];
    int          err_stall = 0, err_gap = 0, err_fd = 0, err_addr = 0;
    logic [7:0]  fbm [2][1024];
    logic [16:0] exp_seq [2048];
    int          exp_n;

    always #5 clk = ~clk;

    ssd1306_frame_streamer #(.HEIGHT(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .cont(cont[0]),
        .fb_we(fb_we[0]), .fb_waddr(fb_waddr[0][8:0]), .fb_wdata(fb_wdata[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_addr(tx_addr[0]), .tx_rw(tx_rw[0]),
        .tx_ctrl(tx_ctrl[0]), .tx_data(tx_data[0]), .tx_last(tx_last[0]),
        .busy(busy[0]), .init_done(init_done[0]), .frame_done(frame_done[0])
    );

    ssd1306_frame_streamer #(.HEIGHT(64), .FLIP(1'b0), .INVERT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .cont(cont[1]),
        .fb_we(fb_we[1]), .fb_waddr(fb_waddr[1]), .fb_wdata(fb_wdata[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_addr(tx_addr[1]), .tx_rw(tx_rw[1]),
        .tx_ctrl(tx_ctrl[1]), .tx_data(tx_data[1]), .tx_last(tx_last[1]),
        .busy(busy[1]), .init_done(init_done[1]), .frame_done(frame_done[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine model: ready is random under backpressure, otherwise always high.
    initial begin
        tx_ready[0] = 1'b1;
        tx_ready[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                tx_ready[k] = bp[k] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Protocol monitor and byte logger, sampled on the falling edge.
    logic        pv [2], pr [2], gp [2], pfd [2];
    logic [16:0] pe [2];
    logic [16:0] mon_e;
    initial begin
        for (int k = 0; k < 2; k++) begin log_n[k] = 0; fd_cnt[k] = 0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                mon_e = {tx_last[k], tx_ctrl[k], tx_data[k]};
                if (!rst_n) begin
                    pv[k] = 1'b0; pr[k] = 1'b0; gp[k] = 1'b0; pfd[k] = 1'b0;
                end else begin
                    if (pv[k] && !pr[k] && ({tx_valid[k], mon_e} !== {1'b1, pe[k]})) err_stall++;
                    if (pv[k] && pr[k]) begin
                        if (tx_valid[k] !== 1'b0) err_gap++;
                        gp[k] = !pe[k][16];
                    end else if (gp[k]) begin
                        if (tx_valid[k] !== 1'b1) err_gap++;
                        gp[k] = 1'b0;
                    end
                    if (frame_done[k]) begin
                        fd_cnt[k]++;
                        if (pfd[k]) err_fd++;
                    end
                    if (tx_valid[k] && ({tx_addr[k], tx_rw[k]} !== {7'h3C, 1'b0})) err_addr++;
                    if (tx_valid[k] && tx_ready[k] && log_n[k] < LOG_MAX) begin
                        log_ent[k][log_n[k]] = mon_e;
                        log_n[k]++;
                    end
                    pv[k] = tx_valid[k]; pr[k] = tx_ready[k]; pe[k] = mon_e; pfd[k] = frame_done[k];
                end
            end
        end
    end

    task automatic exp_push(input logic [7:0] ctrl, input logic [7:0] data, input logic last);
        exp_seq[exp_n] = {last, ctrl, data};
        exp_n++;
    endtask

    task automatic exp_init(input int h, input bit flip, input bit inv);
        logic [7:0] b [26];
        b = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'(h - 1), 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
              8'h20, 8'h00, flip ? 8'hA1 : 8'hA0, flip ? 8'hC8 : 8'hC0, 8'hDA,
              (h == 32) ? 8'h02 : 8'h12, 8'h81, 8'h8F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4,
              inv ? 8'hA7 : 8'hA6, 8'h2E, 8'hAF};
        exp_n = 0;
        for (int i = 0; i < 26; i++) exp_push(8'h00, b[i], i == 25);
    endtask

    task automatic exp_frame(input int k, input int h, input int copies);
        int n;
        n = 128 * h / 8;
        exp_n = 0;
        for (int c = 0; c < copies; c++) begin
            exp_push(8'h00, 8'h21, 1'b0); exp_push(8'h00, 8'h00, 1'b0);
            exp_push(8'h00, 8'h7F, 1'b0); exp_push(8'h00, 8'h22, 1'b0);
            exp_push(8'h00, 8'h00, 1'b0); exp_push(8'h00, 8'(h / 8 - 1), 1'b1);
            for (int i = 0; i < n; i++) exp_push(8'h40, fbm[k][i], i == n - 1);
        end
    endtask

    task automatic cmp_log(input int k, input int base, input string tag);
        int errs = 0;
        chk({tag, "_len"}, 64'(log_n[k] - base), 64'(exp_n));
        for (int i = 0; i < exp_n; i++)
            if (base + i >= log_n[k] || log_ent[k][base + i] !== exp_seq[i]) errs++;
        chk({tag, "_bytes"}, 64'(errs), 64'd0);
    endtask

    task automatic wait_for(input int k, input int what, input int n, input string tag);
        int c = 0;
        bit ok = 1'b0;
        while (!ok && c < 30000) begin
            @(negedge clk); c++;
            case (what)
                W_FD:    ok = frame_done[k];
                W_IDLE:  ok = !busy[k];
                W_INIT:  ok = init_done[k];
                default: ok = (log_n[k] >= n);
            endcase
        end
        chk({tag, "_wait"}, 64'(ok), 64'd1);
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1; start[k] = 1'b1;
        @(posedge clk); #1; start[k] = 1'b0;
    endtask

    task automatic chk_reset_outs(input int k, input string tag);
        chk(tag, {tx_valid[k], tx_addr[k], tx_rw[k], tx_ctrl[k], tx_data[k], tx_last[k],
                  busy[k], init_done[k], frame_done[k]},
                 {1'b0, 7'h3C, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int base, base1, fdb, a, d;
    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; cont[k] = 1'b0; fb_we[k] = 1'b0;
            fb_waddr[k] = '0; fb_wdata[k] = '0; bp[k] = 1'b0;
        end
        @(negedge clk);
        chk_reset_outs(0, "reset_a");
        chk_reset_outs(1, "reset_b");

        // Preload while in reset: fb[i] = i for the 32-row panel, random for the 64-row one.
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            fb_we[0] = (i < 512); fb_waddr[0] = 10'(i); fb_wdata[0] = i[7:0];
            if (i < 512) fbm[0][i] = i[7:0];
            d = $urandom_range(0, 255);
            fb_we[1] = 1'b1; fb_waddr[1] = 10'(i); fb_wdata[1] = 8'(d);
            fbm[1][i] = 8'(d);
        end
        @(posedge clk); #1;
        fb_we[0] = 1'b0; fb_we[1] = 1'b0;
        rst_n = 1'b1;

        wait_for(0, W_INIT, 0, "init_a");
        wait_for(1, W_INIT, 0, "init_b");
        repeat (50) @(negedge clk);
        exp_init(32, 1'b1, 1'b0); cmp_log(0, 0, "init_a");
        exp_init(64, 1'b0, 1'b1); cmp_log(1, 0, "init_b");
        chk("idle_after_init", {busy[0], init_done[0], busy[1], init_done[1]}, 4'b0101);

        // Single frame, engine always ready.
        base = log_n[0]; fdb = fd_cnt[0];
        pulse_start(0);
        wait_for(0, W_FD, 0, "frame1");
        wait_for(0, W_IDLE, 0, "frame1_idle");
        repeat (20) @(negedge clk);
        exp_frame(0, 32, 1); cmp_log(0, base, "frame1");
        chk("frame1_fd_count", 64'(fd_cnt[0] - fdb), 64'd1);

        // Random framebuffer updates, then a frame under random backpressure.
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 511); d = $urandom_range(0, 255);
            @(posedge clk); #1;
            fb_we[0] = 1'b1; fb_waddr[0] = 10'(a); fb_wdata[0] = 8'(d);
            fbm[0][a] = 8'(d);
        end
        @(posedge clk); #1; fb_we[0] = 1'b0;
        bp[0] = 1'b1;
        base = log_n[0];
        pulse_start(0);
        wait_for(0, W_FD, 0, "bp_frame");
        wait_for(0, W_IDLE, 0, "bp_frame_idle");
        exp_frame(0, 32, 1); cmp_log(0, base, "bp_frame");

        // Three starts during a frame queue exactly one more.
        base = log_n[0]; fdb = fd_cnt[0];
        pulse_start(0);
        wait_for(0, W_LOG, base + 100, "mid_frame");
        for (int i = 0; i < 3; i++) begin
            repeat (40) @(posedge clk);
            pulse_start(0);
        end
        wait_for(0, W_FD, 0, "queued_fd1");
        wait_for(0, W_FD, 0, "queued_fd2");
        wait_for(0, W_IDLE, 0, "queued_idle");
        repeat (100) @(negedge clk);
        exp_frame(0, 32, 2); cmp_log(0, base, "queued");
        chk("queued_fd_count", 64'(fd_cnt[0] - fdb), 64'd2);
        chk("queued_busy", busy[0], 1'b0);

        // Continuous refresh: back-to-back frames, no init resend.
        bp[0] = 1'b0;
        base = log_n[0]; fdb = fd_cnt[0];
        @(posedge clk); #1; cont[0] = 1'b1;
        wait_for(0, W_FD, 0, "cont_fd1");
        wait_for(0, W_FD, 0, "cont_fd2");
        wait_for(0, W_FD, 0, "cont_fd3");
        cont[0] = 1'b0;
        wait_for(0, W_IDLE, 0, "cont_idle");
        repeat (20) @(negedge clk);
        exp_frame(0, 32, 3); cmp_log(0, base, "cont");
        chk("cont_fd_count", 64'(fd_cnt[0] - fdb), 64'd3);
        chk("cont_init_done", init_done[0], 1'b1);

        // 128x64 panel frame under backpressure.
        bp[1] = 1'b1;
        base = log_n[1];
        pulse_start(1);
        wait_for(1, W_FD, 0, "frame_b");
        wait_for(1, W_IDLE, 0, "frame_b_idle");
        exp_frame(1, 64, 1); cmp_log(1, base, "frame_b");
        bp[1] = 1'b0;

        // Reset in the middle of the pixel stream.
        base = log_n[0];
        pulse_start(0);
        wait_for(0, W_LOG, base + 6 + 200, "pix200");
        #2 rst_n = 1'b0;
        #1 chk_reset_outs(0, "mid_reset_a");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = log_n[0]; base1 = log_n[1];
        wait_for(0, W_INIT, 0, "reinit_a");
        wait_for(1, W_INIT, 0, "reinit_b");
        repeat (50) @(negedge clk);
        exp_init(32, 1'b1, 1'b0); cmp_log(0, base, "reinit_a");
        exp_init(64, 1'b0, 1'b1); cmp_log(1, base1, "reinit_b");
        chk("reinit_idle", {busy[0], init_done[0]}, 2'b01);

        chk("proto_stall_hold", 64'(err_stall), 64'd0);
        chk("proto_one_idle_gap", 64'(err_gap), 64'd0);
        chk("proto_fd_one_cycle", 64'(err_fd), 64'd0);
        chk("proto_addr_rw", 64'(err_addr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
